// File: rtl/score_bcd_sequencer.sv
// Shared multi-cycle binary-to-BCD converter for two score sources.
// A round-robin arbiter picks a requester, then shift-and-add-3 runs one
// bit per clock on a single working datapath. Each channel keeps its own result.
// LEN_W must stay in 1..9 so the result fits three BCD digits; DIG_W is 4.
module score_bcd_sequencer #(
  parameter int LEN_W = 8,
  parameter int DIG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_W-1:0]     value0,
  input  logic                 req0,
  output logic                 ack0,
  input  logic [LEN_W-1:0]     value1,
  input  logic                 req1,
  output logic                 ack1,
  output logic [3*DIG_W-1:0]   bcd0,
  output logic [3*DIG_W-1:0]   bcd1,
  output logic                 busy
);

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [LEN_W-1:0]   r_shreg;
  logic [DIG_W-1:0]   r_hund;
  logic [DIG_W-1:0]   r_tens;
  logic [DIG_W-1:0]   r_ones;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_id;
  logic               r_last;
  logic [3*DIG_W-1:0] r_bcd0;
  logic [3*DIG_W-1:0] r_bcd1;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_busy;

  logic               w_anyReq;
  logic               w_grantId;
  logic               w_lastStep;
  logic [DIG_W-1:0]   w_adjHund;
  logic [DIG_W-1:0]   w_adjTens;
  logic [DIG_W-1:0]   w_adjOnes;
  logic [DIG_W-1:0]   w_nextHund;
  logic [DIG_W-1:0]   w_nextTens;
  logic [DIG_W-1:0]   w_nextOnes;

  // Arbitration plus one shift-and-add-3 step computed from the current work registers.
  always_comb begin
    w_anyReq   = req0 | req1;
    w_grantId  = (req0 & req1) ? ~r_last : req1;
    w_lastStep = (r_cnt == '0);
    w_adjHund  = (r_hund >= DIG_W'(5)) ? r_hund + DIG_W'(3) : r_hund;
    w_adjTens  = (r_tens >= DIG_W'(5)) ? r_tens + DIG_W'(3) : r_tens;
    w_adjOnes  = (r_ones >= DIG_W'(5)) ? r_ones + DIG_W'(3) : r_ones;
    w_nextHund = {w_adjHund[DIG_W-2:0], w_adjTens[DIG_W-1]};
    w_nextTens = {w_adjTens[DIG_W-2:0], w_adjOnes[DIG_W-1]};
    w_nextOnes = {w_adjOnes[DIG_W-2:0], r_shreg[LEN_W-1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: IDLE waits for a request, SHIFT runs LEN_W steps, DONE lasts one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyReq) w_nextState = SHIFT;
      SHIFT:   if (w_lastStep) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Working datapath: load on grant, shift each SHIFT cycle, commit digits on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg <= '0;
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_cnt   <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_bcd0  <= '0;
      r_bcd1  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_shreg <= w_grantId ? value1 : value0;
            r_hund  <= '0;
            r_tens  <= '0;
            r_ones  <= '0;
            r_cnt   <= CNT_W'(LEN_W - 1);
            r_id    <= w_grantId;
            r_last  <= w_grantId;
          end
        end
        SHIFT: begin
          r_hund  <= w_nextHund;
          r_tens  <= w_nextTens;
          r_ones  <= w_nextOnes;
          r_shreg <= r_shreg << 1;
          if (w_lastStep) begin
            if (r_id) begin
              r_bcd1 <= {w_nextHund, w_nextTens, w_nextOnes};
            end else begin
              r_bcd0 <= {w_nextHund, w_nextTens, w_nextOnes};
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered status: ack pulses during DONE for the granted channel, busy outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ack0 <= (r_state == SHIFT) && w_lastStep && !r_id;
      r_ack1 <= (r_state == SHIFT) && w_lastStep && r_id;
      r_busy <= (w_nextState != IDLE);
    end
  end

  assign ack0 = r_ack0;
  assign ack1 = r_ack1;
  assign bcd0 = r_bcd0;
  assign bcd1 = r_bcd1;
  assign busy = r_busy;

endmodule
